// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - bank of event counters with sticky overflow, atomic snapshot and registered read
//
// Purpose:
//   Counts NUM_EVT single-cycle event strobes in WIDTH-bit counters. All live
//   counters and overflow flags can be copied at once into a shadow bank, and
//   reads are served only from that shadow bank through a registered port, so
//   every value read belongs to one consistent snapshot.
//
// Build option:
//   PERF_SAT_EN  defined   -> counters saturate at all-ones
//                undefined -> counters wrap all-ones -> 0
//   In both builds the overflow flag is set by the first event seen at all-ones.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset
//   evt_i       per-channel event strobes, one event per high cycle
//   ch_en_i     per-channel count enable
//   run_i       global count enable, ANDed with ch_en_i
//   clear_i     synchronous clear of live counters and overflow flags
//   snap_req_i  copy live counters/flags into the shadow bank on this edge
//   snap_ack_o  high for the cycle after a capturing edge
//   rd_sel_i    shadow channel to read
//   rd_data_o   registered shadow counter of rd_sel_i (0 when out of range)
//   rd_ovf_o    registered shadow overflow flag of rd_sel_i (0 when out of range)
//   ovf_o       live sticky overflow flags
//   any_ovf_o   OR of ovf_o
module perf_counter_bank #(
  parameter int WIDTH   = 16,
  parameter int NUM_EVT = 8,
  parameter int SEL_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [NUM_EVT-1:0] ch_en_i,
  input  logic               run_i,
  input  logic               clear_i,
  input  logic               snap_req_i,
  output logic               snap_ack_o,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic               rd_ovf_o,
  output logic [NUM_EVT-1:0] ovf_o,
  output logic               any_ovf_o
);

  logic [WIDTH-1:0]   cnt_q [NUM_EVT];
  logic [WIDTH-1:0]   cnt_d [NUM_EVT];
  logic [NUM_EVT-1:0] ovf_q;
  logic [NUM_EVT-1:0] ovf_d;
  logic [WIDTH-1:0]   shd_q [NUM_EVT];
  logic [WIDTH-1:0]   shd_d [NUM_EVT];
  logic [NUM_EVT-1:0] shd_ovf_q;
  logic [NUM_EVT-1:0] shd_ovf_d;
  logic [WIDTH-1:0]   rd_data_q;
  logic [WIDTH-1:0]   rd_data_d;
  logic               rd_ovf_q;
  logic               rd_ovf_d;
  logic               snap_ack_q;
  logic               snap_ack_d;
  logic [NUM_EVT-1:0] inc;

  assign inc = evt_i & ch_en_i & {NUM_EVT{run_i}};

  // Live counters: clear wins over any event in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_EVT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_i) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (inc[i]) begin
        if (&cnt_q[i]) begin
`ifdef PERF_SAT_EN
          cnt_d[i] = cnt_q[i];
`else
          cnt_d[i] = '0;
`endif
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
      end
    end
  end

  // Shadow captures the pre-edge live state, so same-cycle events and a
  // same-cycle clear are not reflected in the snapshot.
  always_comb begin
    shd_ovf_d = snap_req_i ? ovf_q : shd_ovf_q;
    for (int i = 0; i < NUM_EVT; i++) begin
      shd_d[i] = snap_req_i ? cnt_q[i] : shd_q[i];
    end
  end

  // Read mux over the current shadow; out-of-range selects return zero.
  always_comb begin
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    for (int i = 0; i < NUM_EVT; i++) begin
      if (rd_sel_i == SEL_W'(i)) begin
        rd_data_d = shd_q[i];
        rd_ovf_d  = shd_ovf_q[i];
      end
    end
  end

  assign snap_ack_d = snap_req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_EVT; i++) begin
        cnt_q[i] <= '0;
        shd_q[i] <= '0;
      end
      ovf_q      <= '0;
      shd_ovf_q  <= '0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
      snap_ack_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_EVT; i++) begin
        cnt_q[i] <= cnt_d[i];
        shd_q[i] <= shd_d[i];
      end
      ovf_q      <= ovf_d;
      shd_ovf_q  <= shd_ovf_d;
      rd_data_q  <= rd_data_d;
      rd_ovf_q   <= rd_ovf_d;
      snap_ack_q <= snap_ack_d;
    end
  end

  assign snap_ack_o = snap_ack_q;
  assign rd_data_o  = rd_data_q;
  assign rd_ovf_o   = rd_ovf_q;
  assign ovf_o      = ovf_q;
  assign any_ovf_o  = |ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - self-checking bench for perf_counter_bank against an arithmetic reference model
module tb_perf_counter_bank;

  localparam int W   = 4;
  localparam int N   = 8;
  localparam int S   = 5;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] evt;
  logic [N-1:0] ch_en;
  logic         run;
  logic         clear;
  logic         snap_req;
  logic         snap_ack;
  logic [S-1:0] rd_sel;
  logic [W-1:0] rd_data;
  logic         rd_ovf;
  logic [N-1:0] ovf;
  logic         any_ovf;

  always #5 clk = ~clk;

  perf_counter_bank #(.WIDTH(W), .NUM_EVT(N), .SEL_W(S)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .evt_i      (evt),
    .ch_en_i    (ch_en),
    .run_i      (run),
    .clear_i    (clear),
    .snap_req_i (snap_req),
    .snap_ack_o (snap_ack),
    .rd_sel_i   (rd_sel),
    .rd_data_o  (rd_data),
    .rd_ovf_o   (rd_ovf),
    .ovf_o      (ovf),
    .any_ovf_o  (any_ovf)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: plain integer counts and flags.
  int m_cnt [N];
  int m_shd [N];
  bit m_ovf [N];
  bit m_shd_ovf [N];
  int e_rd;
  bit e_rdo;
  bit e_ack;
  int prev [N];

  function automatic logic [N-1:0] model_ovf_vec();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_shd[i] = 0; m_ovf[i] = 0; m_shd_ovf[i] = 0;
    end
    e_rd = 0; e_rdo = 0; e_ack = 0;
  endtask

  // One rising edge worth of behaviour, from the currently driven inputs.
  task automatic model_edge();
    int n;
    int sel;
    sel = int'(rd_sel);
    if (sel < N) begin
      e_rd = m_shd[sel]; e_rdo = m_shd_ovf[sel];
    end else begin
      e_rd = 0; e_rdo = 0;
    end
    e_ack = snap_req;
    if (snap_req) begin
      for (int i = 0; i < N; i++) begin
        m_shd[i] = m_cnt[i]; m_shd_ovf[i] = m_ovf[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (clear) begin
        m_cnt[i] = 0; m_ovf[i] = 0;
      end else if (evt[i] && ch_en[i] && run) begin
        n = m_cnt[i] + 1;
        if (n > MAX) begin
          m_ovf[i] = 1;
`ifdef PERF_SAT_EN
          n = MAX;
`else
          n = n % (MAX + 1);
`endif
        end
        m_cnt[i] = n;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " ovf"},      32'(ovf),      32'(model_ovf_vec()));
    chk({tag, " any_ovf"},  32'(any_ovf),  32'(|model_ovf_vec()));
    chk({tag, " snap_ack"}, 32'(snap_ack), 32'(e_ack));
    chk({tag, " rd_data"},  32'(rd_data),  32'(e_rd));
    chk({tag, " rd_ovf"},   32'(rd_ovf),   32'(e_rdo));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " ovf"},      32'(ovf),      32'd0);
    chk({tag, " any_ovf"},  32'(any_ovf),  32'd0);
    chk({tag, " snap_ack"}, 32'(snap_ack), 32'd0);
    chk({tag, " rd_data"},  32'(rd_data),  32'd0);
    chk({tag, " rd_ovf"},   32'(rd_ovf),   32'd0);
  endtask

  // Called at a falling edge: drive, take one rising edge, check at the next falling edge.
  task automatic step(input logic [N-1:0] e, input logic [N-1:0] en, input logic r,
                      input logic c, input logic s, input logic [S-1:0] sel);
    evt = e; ch_en = en; run = r; clear = c; snap_req = s; rd_sel = sel;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs("step");
  endtask

  task automatic read_ch(input int ch);
    step('0, '0, 1'b0, 1'b0, 1'b0, S'(ch));
  endtask

  task automatic rand_step();
    step(N'($urandom), N'($urandom), 1'($urandom_range(0, 3) != 0),
         1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0),
         S'($urandom_range(0, 11)));
  endtask

  initial begin
    rst_n = 1'b0; evt = '0; ch_en = '0; run = 1'b0; clear = 1'b0;
    snap_req = 1'b0; rd_sel = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Basic count with channel enables, then out-of-range read.
    repeat (10) step('1, 8'h05, 1'b1, 1'b0, 1'b0, '0);
    step('0, '0, 1'b0, 1'b0, 1'b1, '0);
    chk("basic snap_ack", 32'(snap_ack), 32'd1);
    for (int ch = 0; ch < N; ch++) begin
      read_ch(ch);
      chk($sformatf("basic ch%0d", ch), 32'(rd_data), (ch == 0 || ch == 2) ? 32'd10 : 32'd0);
    end
    read_ch(9);
    chk("basic sel9 data", 32'(rd_data), 32'd0);

    // Snapshot coherency with simultaneous clear.
    step('0, '0, 1'b0, 1'b1, 1'b0, '0);
    repeat (7) step(8'h02, 8'h02, 1'b1, 1'b0, 1'b0, '0);
    step(8'h02, 8'h02, 1'b1, 1'b1, 1'b1, S'(1));
    chk("coh snap_ack", 32'(snap_ack), 32'd1);
    read_ch(1);
    chk("coh shadow ch1", 32'(rd_data), 32'd7);
    chk("coh ack drops", 32'(snap_ack), 32'd0);
    step('0, '0, 1'b0, 1'b0, 1'b1, S'(1));
    read_ch(1);
    chk("coh after clear ch1", 32'(rd_data), 32'd0);

    // Overflow on channel 3.
    step('0, '0, 1'b0, 1'b1, 1'b0, '0);
    repeat (15) step(8'h08, 8'h08, 1'b1, 1'b0, 1'b0, '0);
    chk("ovf before 16th", 32'(ovf[3]), 32'd0);
    step('0, '0, 1'b0, 1'b0, 1'b1, '0);
    read_ch(3);
    chk("ovf cnt15", 32'(rd_data), 32'd15);
    step(8'h08, 8'h08, 1'b1, 1'b0, 1'b0, '0);
    chk("ovf 16th flag", 32'(ovf[3]), 32'd1);
    chk("ovf 16th any", 32'(any_ovf), 32'd1);
    step('0, '0, 1'b0, 1'b0, 1'b1, '0);
    read_ch(3);
`ifdef PERF_SAT_EN
    chk("ovf cnt after 16th", 32'(rd_data), 32'd15);
`else
    chk("ovf cnt after 16th", 32'(rd_data), 32'd0);
`endif
    step(8'h08, 8'h08, 1'b1, 1'b0, 1'b0, '0);
    step('0, '0, 1'b0, 1'b0, 1'b1, '0);
    read_ch(3);
`ifdef PERF_SAT_EN
    chk("ovf cnt after 17th", 32'(rd_data), 32'd15);
`else
    chk("ovf cnt after 17th", 32'(rd_data), 32'd1);
`endif
    chk("ovf shadow flag", 32'(rd_ovf), 32'd1);
    step('0, '0, 1'b0, 1'b1, 1'b0, '0);
    chk("ovf cleared", 32'(any_ovf), 32'd0);
    step('0, '0, 1'b0, 1'b0, 1'b1, '0);
    read_ch(3);
    chk("ovf clr data", 32'(rd_data), 32'd0);
    chk("ovf clr flag", 32'(rd_ovf), 32'd0);

    // run gating.
    repeat (5) step('1, 8'hA6, 1'b1, 1'b0, 1'b0, '0);
    step('0, '0, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < N; i++) prev[i] = m_shd[i];
    repeat (20) step('1, '1, 1'b0, 1'b0, 1'b0, '0);
    step('0, '0, 1'b0, 1'b0, 1'b1, '0);
    for (int ch = 0; ch < N; ch++) begin
      read_ch(ch);
      chk($sformatf("run gate ch%0d", ch), 32'(rd_data), 32'(prev[ch]));
    end

    // Randomized traffic, then a reset in the middle of it.
    repeat (150) rand_step();
    #2 rst_n = 1'b0;
    #1 check_reset_state("midrun reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int ch = 0; ch < N; ch++) read_ch(ch);

    // Reset right after a capturing edge suppresses the acknowledge.
    repeat (20) rand_step();
    evt = '0; ch_en = '0; run = 1'b0; clear = 1'b0; snap_req = 1'b1; rd_sel = '0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort snap_ack", 32'(snap_ack), 32'd0);
    model_reset();
    @(negedge clk);
    snap_req = 1'b0;
    rst_n = 1'b1;

    repeat (300) rand_step();
    step('0, '0, 1'b0, 1'b0, 1'b1, '0);
    for (int ch = 0; ch < N + 2; ch++) read_ch(ch);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

- Parametrised bank of event counters for the pipelined processor.
- Replaces the fixed, simulation-only performance registers: executed instructions, loads, stores, ALU ops, control ops, stalls and cycles.
- Counts NUM_EVT single-cycle event pulses in WIDTH-bit counters, with per-channel enables, sticky overflow flags, atomic snapshot of all channels and a registered read port.
- Sits beside the datapath, fed by pipeline-stage event strobes; read by the testbench or a debug/CSR path.

## Interface
- WIDTH, 16: counter and read-data width (≥2).
- NUM_EVT, 8: number of event channels (1..32).
- SEL_W, 5: width of rd_sel (2^SEL_W ≥ NUM_EVT).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- evt  in  NUM_EVT  event strobes; bit i high for one cycle = one event on channel i.
- ch_en  in  NUM_EVT  per-channel count enable.
- run  in  1  global count enable; ANDed with ch_en.
- clear  in  1  synchronous clear of all counters and overflow flags.
- snap_req  in  1  snapshot request (level, sampled each edge).
- snap_ack  out  1  one-cycle pulse: shadow bank updated.
- rd_sel  in  SEL_W  channel to read from the shadow bank.
- rd_data  out  WIDTH  registered shadow value of channel rd_sel.
- rd_ovf  out  1  registered shadow overflow flag of channel rd_sel.
- ovf  out  NUM_EVT  live sticky overflow flags.
- any_ovf  out  1  OR of ovf.

## Operation
- Counter i increments by 1 on an edge where evt[i] & ch_en[i] & run = 1 and clear = 0.
- Arithmetic is unsigned WIDTH-bit. Wrap mode: all-ones + 1 → 0 and sets ovf[i].
- ovf[i] is sticky: only clear or reset drops it.
- clear has priority over increments: on a clear edge every counter goes to 0 and every ovf to 0, and events in that cycle are lost.
- Snapshot: on an edge with snap_req = 1, all counters and ovf flags are copied into the shadow bank simultaneously.
  - Copied values exclude events presented in that same cycle.
  - snap_req high for k consecutive cycles gives k snapshots and k snap_ack pulses.
- snap_req and clear in the same cycle: shadow captures the pre-clear values; live counters clear.
- Read: on every edge, rd_data ← shadow[rd_sel] and rd_ovf ← shadow_ovf[rd_sel].
  - rd_sel ≥ NUM_EVT returns rd_data = 0 and rd_ovf = 0.
- Live counters are never read directly, so reads are coherent across channels.
- No state machine beyond the snapshot acknowledge. Counters operate independently; no inter-channel ordering.

## Timing
- Reset (rst_n low, asynchronous): counters, ovf, shadow bank, shadow_ovf, rd_data, rd_ovf and snap_ack all go to 0; any_ovf = 0.
- Reset asserted mid-snapshot aborts it: no snap_ack.
- Event latency: an evt at edge N is visible in the counter after edge N.
  - It is visible in the shadow after the next snapshot edge M > N.
  - It is visible on rd_data one edge after M, or later.
- snap_ack goes high for exactly the cycle after the capturing edge.
- Read latency: 1 cycle from rd_sel to rd_data/rd_ovf.
  - A read of a channel in the cycle right after a snapshot returns the new shadow value. (Shadow updates at edge M; rd_data samples it at edge M+1.)
- ovf and any_ovf update on the same edge as the overflowing increment.

## Configuration
- PERF_SAT_EN defined: saturating counters.
  - A counter at all-ones holds its value on further enabled events.
  - ovf[i] is set on the first event attempted at all-ones.
- PERF_SAT_EN undefined: wrap mode, as in Operation.
- All other behaviour is identical in both builds.

## Test plan
- Reset and read:
  - rst_n low mid-run then high; read every channel.
  - Required: rd_data = 0, rd_ovf = 0, ovf = 0, snap_ack = 0.
- Basic count, enables and out-of-range read:
  - Setup: run = 1, ch_en = 8'h05, evt = 8'hFF for 10 cycles, then one snap_req.
  - Required: channels 0 and 2 read 10, all others read 0.
  - rd_sel = 9 reads 0.
- Snapshot coherency and simultaneous clear:
  - Setup: count channel 1 to 7, then snap_req and clear together while evt[1] = 1.
  - Required: shadow[1] = 7 and snap_ack pulses the next cycle.
  - A following snapshot reads 0 (the same-cycle event is dropped).
- Overflow, wrap build:
  - Setup: WIDTH = 4; 17 events on channel 3.
  - Required: after the 16th event, counter = 0 and ovf[3] = any_ovf = 1.
  - After snap, rd_data = 1 and rd_ovf = 1.
- Overflow, PERF_SAT_EN build:
  - Stimulus: same as the wrap case.
  - Required: counter = 15 after the 15th event and stays 15; ovf[3] sets on the 16th event.
  - clear returns counter 0 and ovf 0.
- run gating:
  - Setup: run = 0 with evt = all-ones for 20 cycles, then snap.
  - Required: all channels unchanged from their previous snapshot.
